// File: rtl/alu_chunk_seq_if.sv
// Request/result handshake bundle for alu_chunk_seq: a valid/ready request
// side (operands in) and a valid/ready result side (s/cout out).
interface alu_chunk_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, s, cout
    );

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, s, cout
    );
endinterface

// File: rtl/alu_chunk_seq.sv
// Multi-cycle ALU: evaluates a WIDTH-bit NOR/XOR/ADD/SUB one CHUNK-bit slice
// per clock, carrying between slices in a register.
module alu_chunk_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic           clk,
    input  logic           rst,
    alu_chunk_seq_if.slave bus
);
    localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int OFSW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    localparam logic [1:0] OP_NOR = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b11;

    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("alu_chunk_seq: need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             out_valid_q;

    logic [OFSW-1:0]  bit_ofs;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] b_eff;
    logic [CHUNK-1:0] res_sl;
    logic [CHUNK:0]   sum;
    logic             carry_nxt;

    // Slice datapath: subtraction is a + ~b + carry, so only b needs inverting.
    always_comb begin
        bit_ofs   = OFSW'(32'(idx) * 32'(CHUNK));
        a_sl      = a_q[bit_ofs +: CHUNK];
        b_sl      = b_q[bit_ofs +: CHUNK];
        b_eff     = (op_q == OP_SUB) ? ~b_sl : b_sl;
        sum       = {1'b0, a_sl} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_q};
        case (op_q)
            OP_NOR:  res_sl = ~(a_sl | b_sl);
            OP_XOR:  res_sl = a_sl ^ b_sl;
            default: res_sl = sum[CHUNK-1:0];
        endcase
        carry_nxt = op_q[1] & sum[CHUNK];
    end

    // Control FSM; the carry register doubles as the latched cin at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_NOR;
            carry_q     <= 1'b0;
            idx         <= '0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        op_q    <= bus.op;
                        carry_q <= bus.cin;
                        idx     <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    s_q[bit_ofs +: CHUNK] <= res_sl;
                    carry_q               <= carry_nxt;
                    if (idx == LAST_IDX) begin
                        cout_q      <= carry_nxt;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_alu_chunk_seq.sv
// Bench for alu_chunk_seq: directed scenarios on a (64,8) instance, then
// randomized ops on four geometries against an arithmetic reference model.
module tb_alu_chunk_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   rand_start = 1'b0;
    int   rand_done = 0;

    localparam int CFG_W [4] = '{64, 64, 64, 16};
    localparam int CFG_C [4] = '{8, 64, 1, 4};
    localparam int CFG_N [4] = '{1500, 1500, 400, 1500};

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    alu_chunk_seq_if #(.WIDTH(64)) dbus ();
    alu_chunk_seq #(.WIDTH(64), .CHUNK(8)) dut (.clk(clk), .rst(rst), .bus(dbus));

    // Presents one request, returns just after the accepting edge, then scrambles the inputs.
    task automatic apply_stimulus(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin);
        @(negedge clk);
        check_output("in_ready_before_accept", 64'(dbus.in_ready), 64'd1);
        dbus.op       = op;
        dbus.a        = a;
        dbus.b        = b;
        dbus.cin      = cin;
        dbus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        dbus.in_valid = 1'b0;
        dbus.a        = ~a;
        dbus.b        = ~b;
        dbus.cin      = ~cin;
        dbus.op       = ~op;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (dbus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        dbus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        dbus.out_ready = 1'b0;
        check_output({tag, "_release_out_valid"}, 64'(dbus.out_valid), 64'd0);
        check_output({tag, "_release_in_ready"}, 64'(dbus.in_ready), 64'd1);
    endtask

    // Directed scenarios followed by the randomized phase.
    initial begin
        int lat;
        dbus.in_valid  = 1'b0;
        dbus.a         = '0;
        dbus.b         = '0;
        dbus.cin       = 1'b0;
        dbus.op        = 2'b00;
        dbus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_out_valid", 64'(dbus.out_valid), 64'd0);
        check_output("reset_s", dbus.s, 64'd0);
        check_output("reset_cout", 64'(dbus.cout), 64'd0);
        check_output("reset_in_ready", 64'(dbus.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        apply_stimulus(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        wait_result(lat);
        check_output("add_wrap_latency", 64'(lat), 64'd8);
        check_output("add_wrap_s", dbus.s, 64'd0);
        check_output("add_wrap_cout", 64'(dbus.cout), 64'd1);
        release_result("add_wrap");

        apply_stimulus(2'b11, 64'd5, 64'd7, 1'b1);
        wait_result(lat);
        check_output("sub_borrow_s", dbus.s, 64'hFFFF_FFFF_FFFF_FFFE);
        check_output("sub_borrow_cout", 64'(dbus.cout), 64'd0);
        release_result("sub_borrow");

        apply_stimulus(2'b11, 64'd7, 64'd5, 1'b1);
        wait_result(lat);
        check_output("sub_plain_s", dbus.s, 64'd2);
        check_output("sub_plain_cout", 64'(dbus.cout), 64'd1);
        release_result("sub_plain");

        apply_stimulus(2'b00, 64'd0, 64'hF0, 1'b1);
        wait_result(lat);
        check_output("nor_s", dbus.s, 64'hFFFF_FFFF_FFFF_FF0F);
        check_output("nor_cout", 64'(dbus.cout), 64'd0);
        release_result("nor");

        apply_stimulus(2'b01, 64'h1234, 64'h1234, 1'b1);
        wait_result(lat);
        check_output("xor_s", dbus.s, 64'd0);
        check_output("xor_cout", 64'(dbus.cout), 64'd0);
        release_result("xor");

        apply_stimulus(2'b10, 64'h1111, 64'h2222, 1'b1);
        wait_result(lat);
        check_output("stall_latency", 64'(lat), 64'd8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("stall_out_valid", 64'(dbus.out_valid), 64'd1);
            check_output("stall_s", dbus.s, 64'h3334);
            check_output("stall_cout", 64'(dbus.cout), 64'd0);
            check_output("stall_in_ready", 64'(dbus.in_ready), 64'd0);
            dbus.in_valid = 1'b1;
            dbus.a        = 64'($urandom);
            dbus.op       = 2'b01;
        end
        @(negedge clk);
        dbus.in_valid = 1'b0;
        release_result("stall");
        repeat (12) @(posedge clk);
        #1;
        check_output("stall_nothing_queued", 64'(dbus.out_valid), 64'd0);

        apply_stimulus(2'b10, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("abort_out_valid", 64'(dbus.out_valid), 64'd0);
        check_output("abort_s", dbus.s, 64'd0);
        check_output("abort_cout", 64'(dbus.cout), 64'd0);
        check_output("abort_in_ready", 64'(dbus.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(2'b10, 64'd3, 64'd4, 1'b0);
        wait_result(lat);
        check_output("after_abort_latency", 64'(lat), 64'd8);
        check_output("after_abort_s", dbus.s, 64'd7);
        check_output("after_abort_cout", 64'(dbus.cout), 64'd0);
        release_result("after_abort");

        rand_start = 1'b1;
        for (int c = 0; c < 80000 && rand_done < 4; c++) @(posedge clk);
        check_output("random_all_done", 64'(rand_done), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    for (genvar k = 0; k < 4; k++) begin : g_cfg
        localparam int W  = CFG_W[k];
        localparam int C  = CFG_C[k];
        localparam int NC = W / C;

        alu_chunk_seq_if #(.WIDTH(W)) rbus ();
        alu_chunk_seq #(.WIDTH(W), .CHUNK(C)) rdut (.clk(clk), .rst(rst), .bus(rbus));

        // Random ops with idle gaps, busy-time requests and result stalls.
        initial begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic [W-1:0] s_exp;
            logic [W:0]   full;
            logic [W:0]   cin_ext;
            logic [1:0]   rop;
            logic         rcin;
            logic         c_exp;
            int           lat;
            string        name;
            rbus.in_valid  = 1'b0;
            rbus.a         = '0;
            rbus.b         = '0;
            rbus.cin       = 1'b0;
            rbus.op        = 2'b00;
            rbus.out_ready = 1'b0;
            name = $sformatf("w%0d_c%0d", W, C);
            wait (rand_start);
            for (int n = 0; n < CFG_N[k]; n++) begin
                ra = W'({$urandom, $urandom});
                rb = W'({$urandom, $urandom});
                if ($urandom_range(0, 7) == 0) rb = ~ra;
                rop  = 2'($urandom_range(0, 3));
                rcin = 1'($urandom_range(0, 1));
                cin_ext    = '0;
                cin_ext[0] = rcin;
                case (rop)
                    2'b00:   full = {1'b0, ~(ra | rb)};
                    2'b01:   full = {1'b0, ra ^ rb};
                    2'b10:   full = {1'b0, ra} + {1'b0, rb} + cin_ext;
                    default: full = {1'b0, ra} + {1'b0, ~rb} + cin_ext;
                endcase
                {c_exp, s_exp} = full;

                repeat ($urandom_range(0, 2)) @(negedge clk);
                @(negedge clk);
                check_output({name, "_in_ready"}, 64'(rbus.in_ready), 64'd1);
                rbus.a        = ra;
                rbus.b        = rb;
                rbus.op       = rop;
                rbus.cin      = rcin;
                rbus.in_valid = 1'b1;
                @(posedge clk);
                #1;
                rbus.in_valid = 1'($urandom_range(0, 1));
                rbus.a        = ~ra;
                rbus.b        = W'({$urandom, $urandom});
                rbus.op       = ~rop;
                rbus.cin      = ~rcin;

                lat = 0;
                while (rbus.out_valid !== 1'b1 && lat < NC + 4) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                check_output({name, "_latency"}, 64'(lat), 64'(NC));
                check_output({name, "_s"}, 64'(rbus.s), 64'(s_exp));
                check_output({name, "_cout"}, 64'(rbus.cout), 64'(c_exp));

                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    check_output({name, "_stall_valid"}, 64'(rbus.out_valid), 64'd1);
                    check_output({name, "_stall_s"}, 64'(rbus.s), 64'(s_exp));
                end
                @(negedge clk);
                rbus.in_valid  = 1'b0;
                rbus.out_ready = 1'b1;
                @(posedge clk);
                #1;
                rbus.out_ready = 1'b0;
                check_output({name, "_release"}, 64'(rbus.out_valid), 64'd0);
            end
            rand_done++;
        end
    end
endmodule
